// File: rtl/cnna_mul_pkg.sv
// Shared constants and helpers for the pipelined CNN multiplier.
package cnna_mul_pkg;

    localparam int SAT_WRAP  = 0;
    localparam int SAT_CLAMP = 1;

    // Sign-extended operands plus one bit of headroom for the rounding add.
    function automatic int prod_width(int a_w, int b_w, bit a_s, bit b_s);
        int w;
        w = a_w + b_w + ((a_s && b_s) ? 0 : 1);
        return (w > a_w + b_w) ? w : a_w + b_w + 1;
    endfunction

endpackage

// File: rtl/cnna_mul_pipe_post.sv
// Combinational extend, multiply, round, shift and range check.
module cnna_mul_pipe_post
    import cnna_mul_pkg::*;
#(
    parameter int A_W      = 13,
    parameter int B_W      = 15,
    parameter int P_W      = 16,
    parameter int A_SIGNED = 0,
    parameter int B_SIGNED = 0,
    parameter int SHIFT    = 0,
    parameter int ROUND    = 0,
    parameter int SAT      = 0
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [P_W-1:0] p,
    output logic           ovf
);

    localparam int PW = prod_width(A_W, B_W, A_SIGNED != 0, B_SIGNED != 0);
    localparam bit RES_S = (A_SIGNED != 0) || (B_SIGNED != 0);
    localparam int CW = (PW >= P_W + 2) ? PW : P_W + 2;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [PW-1:0] ONE_P = 1;
    localparam logic signed [PW-1:0] RND =
        (ROUND != 0 && SHIFT > 0) ? (ONE_P <<< RSH) : '0;

    localparam logic signed [CW-1:0] ONE_C = 1;
    localparam logic signed [CW-1:0] MAXV = RES_S ?
        (ONE_C <<< (P_W - 1)) - ONE_C : (ONE_C <<< P_W) - ONE_C;
    localparam logic signed [CW-1:0] MINV = RES_S ?
        -(ONE_C <<< (P_W - 1)) : '0;

    logic signed [PW-1:0] ax;
    logic signed [PW-1:0] bx;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] r;
    logic signed [CW-1:0] rc;
    logic                 over;
    logic                 under;

    always_comb begin
        ax = {{(PW-A_W){(A_SIGNED != 0) ? a[A_W-1] : 1'b0}}, a};
        bx = {{(PW-B_W){(B_SIGNED != 0) ? b[B_W-1] : 1'b0}}, b};
        prod = ax * bx;
        // Unsigned results are never negative here, so >>> equals >>.
        r = (prod + RND) >>> SHIFT;
        rc = CW'(r);
        over = rc > MAXV;
        under = rc < MINV;
        ovf = over || under;
        p = rc[P_W-1:0];
        if (SAT == SAT_CLAMP) begin
            if (over) begin
                p = MAXV[P_W-1:0];
            end else if (under) begin
                p = MINV[P_W-1:0];
            end
        end
    end

endmodule

// File: rtl/cnna_mul_pipe.sv
// Pipelined multiplier with bubble-collapsing valid/ready stages.
module cnna_mul_pipe
    import cnna_mul_pkg::*;
#(
    parameter int A_W       = 13,
    parameter int B_W       = 15,
    parameter int P_W       = 16,
    parameter int A_SIGNED  = 0,
    parameter int B_SIGNED  = 0,
    parameter int SHIFT     = 0,
    parameter int ROUND     = 0,
    parameter int SAT       = 0,
    parameter int NUM_STAGE = 1
) (
    input  logic           ap_clk,
    input  logic           ap_rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] din0,
    input  logic [B_W-1:0] din1,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P_W-1:0] dout,
    output logic           ovf,
    output logic           ovf_sticky,
    input  logic           clr
);

    logic [P_W-1:0] pp;
    logic           pov;

    cnna_mul_pipe_post #(
        .A_W      (A_W),
        .B_W      (B_W),
        .P_W      (P_W),
        .A_SIGNED (A_SIGNED),
        .B_SIGNED (B_SIGNED),
        .SHIFT    (SHIFT),
        .ROUND    (ROUND),
        .SAT      (SAT)
    ) u_post (
        .a   (din0),
        .b   (din1),
        .p   (pp),
        .ovf (pov)
    );

    logic [NUM_STAGE:0]   acc;
    logic [NUM_STAGE-1:0] up_v;
    logic [P_W-1:0]       up_d [NUM_STAGE];
    logic [NUM_STAGE-1:0] up_o;

    logic [NUM_STAGE-1:0] v_q, v_d;
    logic [P_W-1:0]       d_q [NUM_STAGE];
    logic [P_W-1:0]       d_d [NUM_STAGE];
    logic [NUM_STAGE-1:0] o_q, o_d;
    logic                 sticky_q, sticky_d;

    always_comb begin
        acc[NUM_STAGE] = out_ready;
        for (int k = NUM_STAGE - 1; k >= 0; k--) begin
            acc[k] = !v_q[k] || acc[k+1];
        end
        up_v[0] = in_valid;
        up_d[0] = pp;
        up_o[0] = pov;
        for (int k = 1; k < NUM_STAGE; k++) begin
            up_v[k] = v_q[k-1];
            up_d[k] = d_q[k-1];
            up_o[k] = o_q[k-1];
        end
        v_d = v_q;
        d_d = d_q;
        o_d = o_q;
        // Data only moves with a valid token, so bubbles keep the last value.
        for (int k = 0; k < NUM_STAGE; k++) begin
            if (acc[k]) begin
                v_d[k] = up_v[k];
                if (up_v[k]) begin
                    d_d[k] = up_d[k];
                    o_d[k] = up_o[k];
                end
            end
        end
        sticky_d = sticky_q;
        if (clr) begin
            sticky_d = 1'b0;
        end else if (v_q[NUM_STAGE-1] && out_ready && o_q[NUM_STAGE-1]) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            v_q <= '0;
            o_q <= '0;
            sticky_q <= 1'b0;
            for (int k = 0; k < NUM_STAGE; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            o_q <= o_d;
            sticky_q <= sticky_d;
            for (int k = 0; k < NUM_STAGE; k++) begin
                d_q[k] <= d_d[k];
            end
        end
    end

    assign in_ready   = acc[0];
    assign out_valid  = v_q[NUM_STAGE-1];
    assign dout       = d_q[NUM_STAGE-1];
    assign ovf        = o_q[NUM_STAGE-1];
    assign ovf_sticky = sticky_q;

endmodule

// File: doc/cnna_mul_pipe.md
# cnna_mul_pipe

Parametrised, pipelined multiplier with valid/ready flow control and selectable signedness, output scaling, rounding and saturation. It generalises the fixed 13×15→16 unsigned single-stage multiplier cores used in the CNN accelerator datapath. It sits between the line-buffer/weight readers and the accumulator, and absorbs back-pressure from the accumulator without dropping products.

## Interface
- A_W, default 13, operand A width
- B_W, default 15, operand B width
- P_W, default 16, result width
- A_SIGNED, default 0, 1 = operand A is two's complement
- B_SIGNED, default 0, 1 = operand B is two's complement
- SHIFT, default 0, arithmetic right shift applied to the full product (0..A_W+B_W-1)
- ROUND, default 0, 1 = round half-up before the shift (add 2^(SHIFT-1)); ignored when SHIFT=0
- SAT, default 0, 0 = wrap (keep low P_W bits), 1 = saturate to the P_W range
- NUM_STAGE, default 1, register stages from input to output (≥1)
- ap_clk  in  1  clock, rising edge
- ap_rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands this cycle
- din0  in  A_W  operand A
- din1  in  B_W  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- dout  out  P_W  scaled result
- ovf  out  1  saturation/wrap occurred for this result (qualified by out_valid)
- ovf_sticky  out  1  OR of all ovf since reset or last clr
- clr  in  1  synchronous clear of ovf_sticky

## Operation
- Product width A_W+B_W+1 internally. Each operand is sign- or zero-extended per its *_SIGNED flag, so mixed-sign products are exact.
- The result is signed if either operand is signed. Otherwise it is unsigned.
- Scaling: r = (prod + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT. Arithmetic shift when signed, logical when unsigned.
- Range check of r against P_W in the result's signedness:
  - Signed range: [-2^(P_W-1), 2^(P_W-1)-1].
  - Unsigned range: [0, 2^P_W-1].
- Out-of-range handling:
  - SAT=1: clamp to the nearest bound.
  - SAT=0: take the low P_W bits.
  - In both modes ovf=1 for that result.
- The product and post-processing are combinational on the accepted inputs. The result then moves through NUM_STAGE registered stages, each holding {valid, data, ovf}. Synthesis retimes the stages into the DSP.
- Bubble-collapsing pipeline:
  - acc[NUM_STAGE] = out_ready.
  - acc[k] = !v[k] || acc[k+1].
  - in_ready = acc[0].
  - Stage k loads from stage k-1 (or from the inputs for k=0) when acc[k]. Its new valid is the upstream valid.
- out_valid = v[last], dout/ovf = stage[last] data.
- ovf_sticky sets when out_valid && out_ready && ovf. clr has priority over a simultaneous set.

## Timing
- Reset (ap_rst_n low, asynchronous): all v=0, all stage data=0. Therefore out_valid=0, dout=0, ovf=0, ovf_sticky=0. in_ready=1 one combinational settle after reset.
- Reset mid-operation discards all in-flight results. No output is produced for them.
- Latency: NUM_STAGE cycles from an accepted input (in_valid&&in_ready) to out_valid when unstalled.
- Throughput: one result per cycle with out_ready held high.
- Stall with out_ready=0:
  - The pipeline keeps filling empty stages.
  - in_ready drops only when all NUM_STAGE stages are valid.
  - dout and ovf hold stable while out_valid && !out_ready.
- in_ready depends combinationally on out_ready. This path is accepted; there is no skid buffer.
- Inputs are sampled only on in_valid&&in_ready. din0/din1 are don't-care otherwise.

## Structure
- Shared package cnna_mul_pkg holds:
  - constants SAT_WRAP=0 and SAT_CLAMP=1;
  - a function computing the product width from A_W, B_W and the signedness flags.
- One sub-module: cnna_mul_pipe_post. It is purely combinational and performs extend, multiply, round, shift and range check. It is instantiated once ahead of the stage registers.
- Stage registers live in cnna_mul_pipe as arrays indexed by stage.

## Test plan
- Defaults (13/15/16, unsigned, SAT=0, NUM_STAGE=1): din0=8191, din1=32767 → dout=0x6001, ovf=1 one cycle after accept. With SAT=1 → dout=0xFFFF, ovf=1.
- A_SIGNED=1: din0=0x1FFD (-3), din1=5 → dout=0xFFF1 (-15), ovf=0. With SAT=1, din0=0x1000 (-4096), din1=16384 → dout=0x8000, ovf=1.
- SHIFT=4: 7×4 → dout=1 with ROUND=0 and dout=2 with ROUND=1. 3×6 → dout=1 in both.
- NUM_STAGE=3, out_ready=1, back-to-back inputs 1..10 × 2 → outputs 2..20 in order. The first output appears 3 cycles after the first accept; one output per cycle after that.
- NUM_STAGE=3, out_ready=0 for 6 cycles with in_valid=1:
  - exactly 3 inputs accepted, then in_ready=0;
  - dout stable throughout;
  - after out_ready rises, all results delivered in order with no loss or duplication.
- ovf_sticky: an overflowing result is consumed → ovf_sticky=1; clr pulsed in the same cycle as a second overflow consume → ovf_sticky=0. Assert ap_rst_n=0 mid-stream → out_valid=0 immediately.
